// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// No logic; types only.
// Imported by the arbiter top and its address checker.
package mem_arb_pkg;

  localparam int ADDR_WORDS_DEF = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

endpackage

// File: rtl/mem_arb_addr_chk.sv
// Flags a word access that is misaligned or beyond the end of the memory.
// Latency: purely combinational.
// No flow control; evaluated on whatever address is presented.
module mem_arb_addr_chk
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WORDS = ADDR_WORDS_DEF
) (
  input  logic [31:0] adr,
  output logic        err
);

  localparam logic [31:0] WORD_LIMIT = 32'(ADDR_WORDS);

  // misaligned byte address or word index past the last word
  always_comb begin
    err = (adr[1:0] != 2'b00) || ({2'b00, adr[31:2]} >= WORD_LIMIT);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Alternating arbiter sharing one memory between instruction and data ports.
// Latency: request raised in an IDLE cycle is acked the following cycle.
// Requests are held until ack; a port is never served twice in a row.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WORDS = ADDR_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_adr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_adr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        mem_we,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic [15:0] acc_count
);

  state_t      state_q, state_d;
  port_t       last_gnt_q, last_gnt_d;
  logic [15:0] acc_count_q, acc_count_d;

  logic [31:0] serve_adr;
  logic        adr_err;

  // state, fairness pointer and access counter; reset drops any access in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_gnt_q  <= PORT_I;
      acc_count_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      acc_count_q <= acc_count_d;
    end
  end

  // next state: in a SERVE cycle only the other port is considered, so the
  // still-high request of the port being served is never double-served
  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    acc_count_d = acc_count_q;
    case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          state_d = (last_gnt_q == PORT_I) ? SERVE_D : SERVE_I;
        end else if (i_req) begin
          state_d = SERVE_I;
        end else if (d_req) begin
          state_d = SERVE_D;
        end
      end
      SERVE_I: begin
        state_d     = d_req ? SERVE_D : IDLE;
        last_gnt_d  = PORT_I;
        acc_count_d = acc_count_q + 16'h0001;
      end
      SERVE_D: begin
        state_d     = i_req ? SERVE_I : IDLE;
        last_gnt_d  = PORT_D;
        acc_count_d = acc_count_q + 16'h0001;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // address of the port being served this cycle; zero when idle
  always_comb begin
    serve_adr = 32'h0000_0000;
    case (state_q)
      SERVE_I: serve_adr = i_adr;
      SERVE_D: serve_adr = d_adr;
      default: serve_adr = 32'h0000_0000;
    endcase
  end

  mem_arb_addr_chk #(
    .ADDR_WORDS(ADDR_WORDS)
  ) u_addr_chk (
    .adr(serve_adr),
    .err(adr_err)
  );

  // memory-side and port-side outputs decoded from the registered state;
  // a bad address still acks but returns zero data and suppresses the write
  always_comb begin
    i_ack   = 1'b0;
    d_ack   = 1'b0;
    err     = 1'b0;
    mem_we  = 1'b0;
    mem_wd  = 32'h0000_0000;
    i_rdata = 32'h0000_0000;
    d_rdata = 32'h0000_0000;
    case (state_q)
      SERVE_I: begin
        i_ack   = 1'b1;
        err     = adr_err;
        i_rdata = adr_err ? 32'h0000_0000 : mem_rd;
      end
      SERVE_D: begin
        d_ack   = 1'b1;
        err     = adr_err;
        mem_we  = d_we && !adr_err;
        mem_wd  = d_wdata;
        d_rdata = (adr_err || d_we) ? 32'h0000_0000 : mem_rd;
      end
      default: begin
        i_ack = 1'b0;
      end
    endcase
  end

  assign mem_adr   = serve_adr;
  assign acc_count = acc_count_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a queue-based scoreboard.
// Stimulus pushes the expected ack; a negedge monitor pops and compares.
// Every wait on the DUT is bounded.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_adr = '0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_adr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        err;
  logic        mem_we;
  logic [31:0] mem_adr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd = '0;
  logic [15:0] acc_count;

  int n_chk = 0;
  int n_fail = 0;
  bit bulk = 1'b0;

  typedef struct {
    logic        port;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic        err;
    logic        we;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  mem_arbiter #(.ADDR_WORDS(64)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_adr(i_adr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .acc_count(acc_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic port, input logic [31:0] adr, input logic [31:0] wd,
                      input logic [31:0] rdata, input logic e, input logic we,
                      input logic [15:0] cnt);
    exp_t x;
    x.port = port; x.adr = adr; x.wd = wd; x.rdata = rdata;
    x.err = e; x.we = we; x.cnt = cnt;
    sb.push_back(x);
  endtask

  // scoreboard monitor: every ack outside the bulk phase must match the queue head
  always @(negedge clk) begin
    if (!bulk && (i_ack || d_ack)) begin
      chk("ack_exclusive", {31'b0, i_ack & d_ack}, 32'h0);
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected_ack: got i_ack=%0b d_ack=%0b with empty queue", i_ack, d_ack);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_port", {31'b0, d_ack}, {31'b0, e.port});
        chk("rdata", d_ack ? d_rdata : i_rdata, e.rdata);
        chk("err", {31'b0, err}, {31'b0, e.err});
        chk("mem_we", {31'b0, mem_we}, {31'b0, e.we});
        chk("mem_adr", mem_adr, e.adr);
        chk("mem_wd", mem_wd, e.wd);
        chk("acc_count_at_ack", {16'b0, acc_count}, {16'b0, e.cnt});
      end
    end
  end

  task automatic drv_i(input logic [31:0] adr, input int n, output int lat);
    int w;
    lat = 0;
    i_adr = adr;
    i_req = 1'b1;
    for (int k = 0; k < n; k++) begin
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!i_ack && w < 20);
      if (!i_ack) chk("i_ack_timeout", 32'(w), 32'(0));
      if (k == 0) lat = w;
      @(posedge clk);
      #1;
    end
    i_req = 1'b0;
  endtask

  task automatic drv_d(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                       input int n, output int lat);
    int w;
    lat = 0;
    d_we = we;
    d_adr = adr;
    d_wdata = wd;
    d_req = 1'b1;
    for (int k = 0; k < n; k++) begin
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!d_ack && w < 20);
      if (!d_ack) chk("d_ack_timeout", 32'(w), 32'(0));
      if (k == 0) lat = w;
      @(posedge clk);
      #1;
    end
    d_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int li, ld, w, cnt, idle;

    // reset state
    do_reset();
    chk("rst_i_ack", {31'b0, i_ack}, 32'h0);
    chk("rst_d_ack", {31'b0, d_ack}, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_mem_adr", mem_adr, 32'h0);
    chk("rst_mem_wd", mem_wd, 32'h0);
    chk("rst_acc_count", {16'b0, acc_count}, 32'h0);

    // single instruction fetch
    mem_rd = 32'h2002_0005;
    push(1'b0, 32'h8, 32'h0, 32'h2002_0005, 1'b0, 1'b0, 16'd0);
    drv_i(32'h8, 1, li);
    chk("fetch_latency", 32'(li), 32'd2);
    chk("fetch_acc_count", {16'b0, acc_count}, 32'd1);

    // tie straight after reset: data wins, then instruction
    do_reset();
    mem_rd = 32'h1234_5678;
    push(1'b1, 32'h4, 32'h0, 32'h1234_5678, 1'b0, 1'b0, 16'd0);
    push(1'b0, 32'h8, 32'h0, 32'h1234_5678, 1'b0, 1'b0, 16'd1);
    fork
      drv_d(1'b0, 32'h4, 32'h0, 1, ld);
      drv_i(32'h8, 1, li);
    join
    chk("tie_d_latency", 32'(ld), 32'd2);
    chk("tie_i_latency", 32'(li), 32'd3);
    chk("tie_acc_count", {16'b0, acc_count}, 32'd2);
    chk("tie_back_idle", {30'b0, i_ack, d_ack}, 32'h0);

    // saturation: both held for six accesses, D write at top word
    mem_rd = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      push(1'b1, 32'hFC, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1, 16'(2 + 2 * k));
      push(1'b0, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 16'(3 + 2 * k));
    end
    idle = 0;
    fork
      drv_d(1'b1, 32'hFC, 32'hCAFE_F00D, 3, ld);
      drv_i(32'h0, 3, li);
      begin
        w = 0;
        do begin
          @(negedge clk);
          w++;
        end while (!(i_ack || d_ack) && w < 10);
        repeat (5) begin
          @(negedge clk);
          if (!(i_ack || d_ack)) idle++;
        end
      end
    join
    chk("sat_no_idle", 32'(idle), 32'd0);
    chk("sat_d_first_latency", 32'(ld), 32'd2);
    chk("sat_acc_count", {16'b0, acc_count}, 32'd8);

    // out-of-range and misaligned accesses, then a good data read
    push(1'b1, 32'h100, 32'hBADB_AD01, 32'h0, 1'b1, 1'b0, 16'd8);
    drv_d(1'b1, 32'h100, 32'hBADB_AD01, 1, ld);
    push(1'b1, 32'h6, 32'hBADB_AD01, 32'h0, 1'b1, 1'b0, 16'd9);
    drv_d(1'b1, 32'h6, 32'hBADB_AD01, 1, ld);
    push(1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 1'b0, 16'd10);
    drv_i(32'h101, 1, li);
    push(1'b1, 32'hFC, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 16'd11);
    drv_d(1'b0, 32'hFC, 32'h0, 1, ld);
    chk("err_acc_count", {16'b0, acc_count}, 32'd12);

    // reset in the middle of a data write
    d_we = 1'b1;
    d_adr = 32'h10;
    d_wdata = 32'h1111_2222;
    d_req = 1'b1;
    @(posedge clk);
    #2;
    chk("pre_rst_mem_we", {31'b0, mem_we}, 32'h1);
    reset = 1'b0;
    #1;
    chk("mid_rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("mid_rst_d_ack", {31'b0, d_ack}, 32'h0);
    chk("mid_rst_mem_adr", mem_adr, 32'h0);
    chk("mid_rst_acc_count", {16'b0, acc_count}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    push(1'b1, 32'h10, 32'h1111_2222, 32'h0, 1'b0, 1'b1, 16'd0);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!d_ack && w < 20);
    chk("post_rst_latency", 32'(w), 32'd2);
    @(posedge clk);
    #1;
    d_req = 1'b0;
    chk("post_rst_acc_count", {16'b0, acc_count}, 32'd1);

    // counter wrap: 65535 accesses with both ports saturated, then one more
    do_reset();
    bulk = 1'b1;
    i_adr = 32'h0;
    d_adr = 32'h0;
    d_we = 1'b0;
    i_req = 1'b1;
    d_req = 1'b1;
    cnt = 0;
    w = 0;
    while (cnt < 65535 && w < 70000) begin
      @(negedge clk);
      w++;
      if (i_ack || d_ack) cnt++;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    @(posedge clk);
    #1;
    bulk = 1'b0;
    chk("bulk_ack_count", 32'(cnt), 32'd65535);
    chk("pre_wrap_acc_count", {16'b0, acc_count}, 32'h0000_FFFF);
    mem_rd = 32'h0BAD_CAFE;
    push(1'b0, 32'h0, 32'h0, 32'h0BAD_CAFE, 1'b0, 1'b0, 16'hFFFF);
    drv_i(32'h0, 1, li);
    chk("wrap_acc_count", {16'b0, acc_count}, 32'h0);

    repeat (2) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
